// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS decode stage:
//   - opcode and funct constants for the supported instruction subset
//   - alu_op_e : 4-bit ALU opcode carried into execute (ALU_NOP encodes as 0)
//   - id_ex_t  : the ID/EX pipeline bundle
//   - ID_EX_BUBBLE : the all-zero bundle used for bubbles and reset
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_SLT = 4'd5
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc_inc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        alu_op_e     alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        wb_en;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_stage_if.sv
// ---------------------------------------------------------------------------
// id_stage_if
// Writeback port from WB into the decode stage's register file.
//   wb_en    : writeback enable
//   wb_dest  : destination register index
//   wb_value : data to write
// modport master : the writeback stage (drives)
// modport slave  : the decode stage / register file (receives)
// ---------------------------------------------------------------------------
interface id_stage_if;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;

    modport master (output wb_en, output wb_dest, output wb_value);
    modport slave  (input  wb_en, input  wb_dest, input  wb_value);
endinterface

// File: rtl/id_stage_register_file.sv
// ---------------------------------------------------------------------------
// register_file
// 32x32 (REG_COUNT entries) architectural register file for the decode stage.
//   clk, rst          : clock, asynchronous active-high reset
//   wb                : writeback port (id_stage_if.slave), synchronous write
//   rs_addr, rt_addr  : read indices
//   rs_val, rt_val    : combinational read data
// Reset clears every register except $29, which takes RESET_SP.
// $0 is hard-wired to zero; writes to it are dropped.
// Optional build macro ID_WB_BYPASS_EN: a read of the register being written
// this cycle returns wb_value (write-through); otherwise the pre-write value.
// ---------------------------------------------------------------------------
module register_file
    import mips_pkg::*;
#(
    parameter int          REG_COUNT = 32,
    parameter logic [31:0] RESET_SP  = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    id_stage_if.slave         wb,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [31:0]       rs_val,
    output logic [31:0]       rt_val
);

    localparam int IDX_W  = $clog2(REG_COUNT);
    localparam int SP_IDX = 29;

    logic [31:0] regs_q [REG_COUNT];
    logic [31:0] regs_d [REG_COUNT];
    logic        wr_en;

    assign wr_en = wb.wb_en && (wb.wb_dest != 5'd0);

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and start from a full
        // default so every path assigns every bit and no latch is inferred.
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wb.wb_dest[IDX_W-1:0]] = wb.wb_value;
        end
        regs_d[0] = '0;
    end

    // NOTE: this storage is a reset flop array (it must come up with a known
    // stack pointer), so it cannot map onto a RAM macro without reset support.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= (i == SP_IDX) ? RESET_SP : 32'h0;
            end
        end else begin
            // NOTE: sequential state is updated with non-blocking '<=' only.
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs_val = regs_q[rs_addr[IDX_W-1:0]];
`ifdef ID_WB_BYPASS_EN
        if (wr_en && (wb.wb_dest == rs_addr)) begin
            rs_val = wb.wb_value;
        end
`endif
    end

    always_comb begin
        rt_val = regs_q[rt_addr[IDX_W-1:0]];
`ifdef ID_WB_BYPASS_EN
        if (wr_en && (wb.wb_dest == rt_addr)) begin
            rt_val = wb.wb_value;
        end
`endif
    end

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
// MIPS instruction-decode stage: decodes control, reads the register file,
// sign-extends the immediate, resolves BEQ/BNE/J and registers the ID/EX
// bundle.
//   clk, rst              : clock, asynchronous active-high reset
//   PC_inc, Instruction   : PC+4 and instruction from IF/ID
//   id_valid              : IF/ID holds a real instruction
//   stall, flush_ex       : hazard unit; either one bubbles ID/EX
//   wb                    : writeback port (id_stage_if.slave)
//   Br_taken, Br_Addr     : combinational redirect to fetch
//   ex_*                  : registered ID/EX bundle
// Branches and jumps are finished here, so they travel into EX as NOPs; SW
// carries ALU_ADD for its address but writes no register.
// Optional build macro ID_WB_BYPASS_EN enables register-file write-through.
// ---------------------------------------------------------------------------
module id_stage
    import mips_pkg::*;
#(
    parameter int          REG_COUNT = 32,
    parameter logic [31:0] RESET_SP  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_inc,
    input  logic [31:0] Instruction,
    input  logic        id_valid,
    input  logic        stall,
    input  logic        flush_ex,
    id_stage_if.slave   wb,
    output logic        Br_taken,
    output logic [31:0] Br_Addr,
    output logic [31:0] ex_pc_inc,
    output logic [31:0] ex_rs_val,
    output logic [31:0] ex_rt_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dest,
    output alu_op_e     ex_alu_op,
    output logic        ex_alu_src,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_wb_en
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        is_j;
    logic        is_beq;
    logic        is_bne;
    logic        operands_eq;
    id_ex_t      dec;
    id_ex_t      id_ex_d;
    id_ex_t      id_ex_q;

    assign opcode = Instruction[31:26];
    assign rs     = Instruction[25:21];
    assign rt     = Instruction[20:16];
    assign rd     = Instruction[15:11];
    assign funct  = Instruction[5:0];
    assign imm    = {{16{Instruction[15]}}, Instruction[15:0]};

    register_file #(
        .REG_COUNT (REG_COUNT),
        .RESET_SP  (RESET_SP)
    ) u_register_file (
        .clk     (clk),
        .rst     (rst),
        .wb      (wb),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_val  (rs_val),
        .rt_val  (rt_val)
    );

    // Branch / jump resolution
    assign is_j        = (opcode == OP_J);
    assign is_beq      = (opcode == OP_BEQ);
    assign is_bne      = (opcode == OP_BNE);
    assign operands_eq = (rs_val == rt_val);
    assign br_target   = PC_inc + {imm[29:0], 2'b00};
    assign j_target    = {PC_inc[31:28], Instruction[25:0], 2'b00};

    // rst gates the redirect directly: a J needs no register operand, so the
    // cleared register file alone would not suppress it.
    assign Br_taken = ~rst & id_valid & ~stall &
                      (is_j | (is_beq & operands_eq) | (is_bne & ~operands_eq));
    assign Br_Addr  = is_j ? j_target : br_target;

    // Control decode
    always_comb begin
        dec        = ID_EX_BUBBLE;
        dec.pc_inc = PC_inc;
        dec.rs     = rs;
        dec.rt     = rt;
        dec.rs_val = rs_val;
        dec.rt_val = rt_val;
        dec.imm    = imm;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    default: dec.alu_op = ALU_NOP;
                endcase
                if (dec.alu_op != ALU_NOP) begin
                    dec.dest  = rd;
                    dec.wb_en = 1'b1;
                end
            end
            OP_ADDI: begin
                dec.alu_op  = ALU_ADD;
                dec.alu_src = 1'b1;
                dec.dest    = rt;
                dec.wb_en   = 1'b1;
            end
            OP_LW: begin
                dec.alu_op   = ALU_ADD;
                dec.alu_src  = 1'b1;
                dec.mem_read = 1'b1;
                dec.dest     = rt;
                dec.wb_en    = 1'b1;
            end
            OP_SW: begin
                dec.alu_op    = ALU_ADD;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            // BEQ/BNE/J resolve here; they and unknown opcodes reach EX as NOPs.
            default: ;
        endcase
        // A $0 destination never writes, so 32'h0 is a clean NOP.
        if (dec.dest == 5'd0) begin
            dec.wb_en = 1'b0;
        end
    end

    // ID/EX register
    always_comb begin
        id_ex_d = dec;
        if (stall || flush_ex || !id_valid) begin
            id_ex_d = ID_EX_BUBBLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q <= ID_EX_BUBBLE;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign ex_pc_inc    = id_ex_q.pc_inc;
    assign ex_rs_val    = id_ex_q.rs_val;
    assign ex_rt_val    = id_ex_q.rt_val;
    assign ex_imm       = id_ex_q.imm;
    assign ex_rs        = id_ex_q.rs;
    assign ex_rt        = id_ex_q.rt;
    assign ex_dest      = id_ex_q.dest;
    assign ex_alu_op    = id_ex_q.alu_op;
    assign ex_alu_src   = id_ex_q.alu_src;
    assign ex_mem_read  = id_ex_q.mem_read;
    assign ex_mem_write = id_ex_q.mem_write;
    assign ex_wb_en     = id_ex_q.wb_en;

endmodule
